// File: rtl/diff_tx_pkg.sv
// rtl/diff_tx_pkg.sv - shared constants and state type for the differential serial TX arbiter
package diff_tx_pkg;

    localparam int NUM_REQ    = 4;
    localparam int ID_W       = 2;
    localparam int FRAME_BITS = 13;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GUARD
    } tx_state_t;

endpackage

// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - combinational four-way round-robin selector
module rr_arbiter_4
    import diff_tx_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               any_req
);

    logic [ID_W-1:0] idx;

    // Walk from furthest to nearest so the requester right after last_grant wins.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        idx      = '0;
        any_req  = |req;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = last_grant + ID_W'(k);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_id   = idx;
            end
        end
    end

endmodule

// File: rtl/diff_tx_arbiter.sv
// rtl/diff_tx_arbiter.sv - arbitrates four byte sources onto one framed serial line
module diff_tx_arbiter
    import diff_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int GUARD_BITS   = 1
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    ENABLE,
    input  logic [NUM_REQ-1:0]      REQ_VALID,
    input  logic [8*NUM_REQ-1:0]    REQ_DATA,
    output logic [NUM_REQ-1:0]      REQ_READY,
    output logic                    D_OUT,
    output logic                    BUSY,
    output logic [ID_W-1:0]         GRANT_ID,
    output logic                    FRAME_DONE
);

    localparam int CYC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int GRD_W = $clog2(15 * 1024);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLKS_PER_BIT - 1);
    localparam logic [GRD_W-1:0] GRD_LAST = GRD_W'(GUARD_BITS * CLKS_PER_BIT - 1);
    localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);

    tx_state_t                state, state_nxt;
    logic [FRAME_BITS-1:0]    shreg;
    logic [CYC_W-1:0]         cyc_cnt;
    logic [3:0]               bit_cnt;
    logic [GRD_W-1:0]         guard_cnt;
    logic [ID_W-1:0]          last_grant;
    logic [ID_W-1:0]          grant_id_reg;

    logic [NUM_REQ-1:0]       win_onehot;
    logic [ID_W-1:0]          win_id;
    logic                     any_req;
    logic                     grant_en;
    logic                     accept;
    logic                     bit_end;
    logic                     last_bit;
    logic [7:0]               sel_data;
    logic [FRAME_BITS-1:0]    frame;

    rr_arbiter_4 u_rr (
        .req        (REQ_VALID),
        .last_grant (last_grant),
        .grant      (win_onehot),
        .grant_id   (win_id),
        .any_req    (any_req)
    );

    assign grant_en  = (state == IDLE) && ENABLE && !RESET;
    assign REQ_READY = grant_en ? win_onehot : '0;
    assign accept    = grant_en && any_req;

    // Frame is stored LSB-first: bit 0 is the start bit, bit 12 the stop bit.
    assign sel_data = REQ_DATA[{win_id, 3'b000} +: 8];
    assign frame    = {1'b1, ^{sel_data, win_id}, sel_data, win_id, 1'b0};

    assign bit_end  = (cyc_cnt == CYC_LAST);
    assign last_bit = (bit_cnt == BIT_LAST);

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (bit_end && last_bit) state_nxt = (GUARD_BITS == 0) ? IDLE : GUARD;
            GUARD:   if (guard_cnt == GRD_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Idle line is high, so the shifter back-fills with ones.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            shreg        <= '1;
            cyc_cnt      <= '0;
            bit_cnt      <= '0;
            guard_cnt    <= '0;
            last_grant   <= ID_W'(NUM_REQ - 1);
            grant_id_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cyc_cnt   <= '0;
                    bit_cnt   <= '0;
                    guard_cnt <= '0;
                    if (accept) begin
                        shreg        <= frame;
                        last_grant   <= win_id;
                        grant_id_reg <= win_id;
                    end
                end
                SHIFT: begin
                    guard_cnt <= '0;
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        shreg   <= {1'b1, shreg[FRAME_BITS-1:1]};
                        bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                GUARD: begin
                    guard_cnt <= guard_cnt + 1'b1;
                end
                default: begin
                    shreg <= '1;
                end
            endcase
        end
    end

    assign D_OUT      = shreg[0];
    assign BUSY       = (state != IDLE) && !RESET;
    assign GRANT_ID   = grant_id_reg;
    assign FRAME_DONE = (state == SHIFT) && bit_end && last_bit && !RESET;

endmodule

// File: tb/tb_diff_tx_arbiter.sv
// tb/tb_diff_tx_arbiter.sv - directed self-checking bench for diff_tx_arbiter
module tb_diff_tx_arbiter;

    logic        CLK = 1'b0;
    logic        rst, en;
    logic [3:0]  rv, rv_z;
    logic [31:0] rd, rd_z;
    logic [3:0]  rr, rr_z;
    logic        dout, dout_z, busy, busy_z, fd, fd_z;
    logic [1:0]  gid, gid_z;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    diff_tx_arbiter #(.CLKS_PER_BIT(4), .GUARD_BITS(1)) dut (
        .CLK(CLK), .RESET(rst), .ENABLE(en), .REQ_VALID(rv), .REQ_DATA(rd),
        .REQ_READY(rr), .D_OUT(dout), .BUSY(busy), .GRANT_ID(gid), .FRAME_DONE(fd)
    );

    diff_tx_arbiter #(.CLKS_PER_BIT(4), .GUARD_BITS(0)) dut_z (
        .CLK(CLK), .RESET(rst), .ENABLE(en), .REQ_VALID(rv_z), .REQ_DATA(rd_z),
        .REQ_READY(rr_z), .D_OUT(dout_z), .BUSY(busy_z), .GRANT_ID(gid_z), .FRAME_DONE(fd_z)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  exp_ready;
        logic [1:0]  exp_id;
        logic [12:0] exp_frame;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v);
        int k, bad, done_cnt, done_at;
        @(negedge CLK);
        rv = v.valid;
        rd = v.data;
        #1;
        k = 0;
        while (rr == 4'b0 && k < 200) begin
            @(negedge CLK);
            #1;
            k++;
        end
        check("vec_ready", 32'(rr), 32'(v.exp_ready));
        @(negedge CLK);
        rv = 4'b0;
        rd = ~rd;
        check("vec_grant_id", 32'(gid), 32'(v.exp_id));
        bad = 0; done_cnt = 0; done_at = -1;
        for (int c = 1; c <= 57; c++) begin
            if (c > 1) @(negedge CLK);
            if (c <= 52 && dout !== v.exp_frame[(c-1)/4]) bad++;
            if (c > 52 && c <= 56 && dout !== 1'b1) bad++;
            if (c <= 56 && busy !== 1'b1) bad++;
            if (c == 57 && busy !== 1'b0) bad++;
            if (fd === 1'b1) begin done_cnt++; done_at = c; end
        end
        check("vec_line_and_busy", 32'(bad), 0);
        check("vec_frame_done_cycle", 32'(done_at), 52);
        check("vec_frame_done_count", 32'(done_cnt), 1);
    endtask

    function automatic int idx_of(input logic [3:0] oh);
        int r = 9;
        for (int i = 0; i < 4; i++) if (oh[i]) r = i;
        return r;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int ids[$];
        int times[$];
        int cyc, bad, cnt, prev, at;
        int exp_ids[5] = '{0, 1, 2, 3, 0};

        vecs[0] = '{4'b0001, 32'h000000A5, 4'b0001, 2'd0, 13'h1528};
        vecs[1] = '{4'b0100, 32'h00010000, 4'b0100, 2'd2, 13'h100C};
        vecs[2] = '{4'b1111, 32'hC3332211, 4'b1000, 2'd3, 13'h161E};
        vecs[3] = '{4'b0110, 32'h00007E00, 4'b0010, 2'd1, 13'h1BF2};
        vecs[4] = '{4'b0001, 32'h000000FF, 4'b0001, 2'd0, 13'h17F8};

        rst = 1'b1; en = 1'b1; rv = 4'hF; rd = '0; rv_z = '0; rd_z = '0;
        repeat (3) @(negedge CLK);
        #1;
        check("rst_dout", 32'(dout), 1);
        check("rst_ready", 32'(rr), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_grant_id", 32'(gid), 0);
        check("rst_frame_done", 32'(fd), 0);
        rv = 4'b0;
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_frame(vecs[i]);

        // Contention: all four held valid after a fresh reset.
        @(negedge CLK); rst = 1'b1;
        @(negedge CLK); rst = 1'b0; rv = 4'hF; rd = 32'h44332211;
        cyc = 0; prev = 0; bad = 0;
        #1;
        for (int c = 0; c < 400 && ids.size() < 5; c++) begin
            if (c > 0) begin @(negedge CLK); #1; end
            cyc++;
            if (rr != 4'b0) begin
                if (prev != 0) bad++;
                ids.push_back(idx_of(rr));
                times.push_back(cyc);
            end
            prev = (rr != 4'b0) ? 1 : 0;
        end
        check("rr_grant_count", 32'(ids.size()), 5);
        check("rr_pulse_width", 32'(bad), 0);
        for (int i = 0; i < 5; i++)
            check("rr_order", (ids.size() > i) ? 32'(ids[i]) : 32'hFF, 32'(exp_ids[i]));
        for (int i = 1; i < 5; i++)
            check("rr_spacing", (times.size() > i) ? 32'(times[i] - times[i-1]) : 32'hFF, 57);

        // ENABLE dropped mid-frame: frame finishes, no new grants.
        repeat (10) @(negedge CLK);
        en = 1'b0;
        bad = 0; cnt = 0;
        for (int c = 0; c < 120; c++) begin
            @(negedge CLK); #1;
            if (rr != 4'b0) bad++;
            if (fd === 1'b1) cnt++;
        end
        check("en_no_ready", 32'(bad), 0);
        check("en_frame_completes", 32'(cnt), 1);
        check("en_idle_busy", 32'(busy), 0);
        en = 1'b1;
        #1;
        check("en_resume_grant", 32'(rr), 32'b0010);

        // Reset during data bits aborts the frame.
        repeat (20) @(negedge CLK);
        rv = 4'b0;
        rst = 1'b1;
        @(negedge CLK);
        check("mid_rst_dout", 32'(dout), 1);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(fd), 0);
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge CLK);
            if (fd !== 1'b0 || dout !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("mid_rst_quiet", 32'(bad), 0);
        rv = 4'hF;
        #1;
        check("mid_rst_first_grant", 32'(rr), 32'b0001);
        rv = 4'b0;

        // Zero guard: next grant right after FRAME_DONE, start bit one cycle later.
        @(negedge CLK);
        rv_z = 4'hF; rd_z = 32'h12345678;
        #1;
        cnt = 0;
        while (rr_z == 4'b0 && cnt < 100) begin @(negedge CLK); #1; cnt++; end
        check("z_first_grant", 32'(rr_z), 32'b0001);
        at = -1;
        for (int c = 1; c <= 60 && at < 0; c++) begin
            @(negedge CLK);
            if (fd_z === 1'b1) at = c;
        end
        check("z_done_cycle", 32'(at), 52);
        @(negedge CLK); #1;
        check("z_back_to_back_ready", 32'(rr_z), 32'b0010);
        @(negedge CLK);
        check("z_next_start_bit", 32'(dout_z), 0);
        check("z_next_busy", 32'(busy_z), 1);
        rv_z = 4'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
